threshold_debouncer: RTL

//   Registered stage directly downstream of the magnitude comparator.

---
 rtl/threshold_debouncer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/threshold_debouncer.sv
// Debounces magnitude-comparator flags into a stable above/below level with crossing pulses.
// Optional crossing event counter enabled by defining THRESH_EVENT_CNT_EN.
module threshold_debouncer #(
   parameter int DEBOUNCE  = 3,
   parameter int CNT_WIDTH = 4,
   parameter int EVT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 eq,
   input  logic                 lt,
   input  logic                 gt,
   output logic                 known,
   output logic                 above,
   output logic                 rise,
   output logic                 fall,
   output logic [CNT_WIDTH-1:0] run_cnt,
   output logic [EVT_WIDTH-1:0] evt_cnt
);

   typedef enum logic [1:0] {IDLE, BELOW, ABOVE} state_t;

   localparam logic [CNT_WIDTH-1:0] DEB = CNT_WIDTH'(DEBOUNCE);
   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
   logic                 dir_q, dir_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 up, down;
   logic [CNT_WIDTH-1:0] cnt_inc, idle_next;

   // Only a strictly one-hot gt or lt counts; eq and illegal combinations are holds.
   assign up        = in_valid & gt & ~lt & ~eq;
   assign down      = in_valid & lt & ~gt & ~eq;
   assign cnt_inc   = run_cnt_q + ONE;
   assign idle_next = (dir_q == up) ? cnt_inc : ONE;

   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      dir_d     = dir_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (up || down) begin
               dir_d = up;
               // The first decision sets the level silently, without a crossing pulse.
               if (idle_next == DEB) begin
                  state_d   = up ? ABOVE : BELOW;
                  run_cnt_d = '0;
               end else begin
                  run_cnt_d = idle_next;
               end
            end
         end
         BELOW: begin
            if (up) begin
               if (cnt_inc == DEB) begin
                  state_d   = ABOVE;
                  run_cnt_d = '0;
                  rise_d    = 1'b1;
               end else begin
                  run_cnt_d = cnt_inc;
               end
            end else if (down) begin
               run_cnt_d = '0;
            end
         end
         ABOVE: begin
            if (down) begin
               if (cnt_inc == DEB) begin
                  state_d   = BELOW;
                  run_cnt_d = '0;
                  fall_d    = 1'b1;
               end else begin
                  run_cnt_d = cnt_inc;
               end
            end else if (up) begin
               run_cnt_d = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            run_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         run_cnt_q <= '0;
         dir_q     <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
         dir_q     <= dir_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign known   = (state_q != IDLE);
   assign above   = (state_q == ABOVE);
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign run_cnt = run_cnt_q;

`ifdef THRESH_EVENT_CNT_EN
   logic [EVT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;

   // Counts alongside the registered pulse so evt_cnt steps in the same cycle rise/fall shows.
   assign evt_cnt_d = evt_cnt_q + EVT_WIDTH'(rise_d | fall_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_cnt_q <= '0;
      end else begin
         evt_cnt_q <= evt_cnt_d;
      end
   end

   assign evt_cnt = evt_cnt_q;
`else
   assign evt_cnt = '0;
`endif

endmodule
